decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: combinational field/ID decode feeding a one-entry
// valid/ready output register with an accepted-instruction counter.
module decode_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SIGN_EXT   = 0,
    parameter int unsigned MAX_OPCODE = 21,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  id,
    output logic [XLEN-1:0]  rs,
    output logic [XLEN-1:0]  rt,
    output logic [XLEN-1:0]  rd,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned IMM_W = 16;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J
    } fmt_e;

    logic [5:0]       w_opcode;
    logic [5:0]       w_func;
    logic [XLEN-1:0]  w_imm;
    logic             w_illegal;
    fmt_e             w_fmt;
    logic [XLEN-1:0]  w_id;
    logic [XLEN-1:0]  w_rs;
    logic [XLEN-1:0]  w_rt;
    logic [XLEN-1:0]  w_rd;
    logic             w_accept;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_id;
    logic [XLEN-1:0]  r_rs;
    logic [XLEN-1:0]  r_rt;
    logic [XLEN-1:0]  r_rd;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    assign w_opcode  = ir[31:26];
    assign w_func    = ir[5:0];
    assign w_illegal = 32'(w_opcode) > MAX_OPCODE;
    assign w_imm     = (SIGN_EXT != 0) ? {{(XLEN-IMM_W){ir[15]}}, ir[15:0]}
                                       : XLEN'(ir[15:0]);

    // Opcode -> instruction ID and operand format
    always_comb begin
        w_id  = '0;
        w_fmt = FMT_R;
        case (w_opcode)
            6'd0: begin
                w_id  = XLEN'(w_func) + XLEN'(1);
                w_fmt = FMT_R;
            end
            6'd1, 6'd2, 6'd5, 6'd6: begin
                w_id  = XLEN'(w_opcode) + XLEN'(4);
                w_fmt = FMT_I;
            end
            6'd3, 6'd4: begin
                w_id  = XLEN'(w_opcode) + XLEN'(4);
                w_fmt = FMT_R;
            end
            6'd7: begin
                w_id  = XLEN'(w_func) + XLEN'(11);
                w_fmt = FMT_I;
            end
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd20: begin
                w_id  = XLEN'(w_opcode) + XLEN'(5);
                w_fmt = FMT_I;
            end
            6'd16, 6'd17, 6'd18: begin
                w_id  = XLEN'(w_opcode) + XLEN'(5);
                w_fmt = FMT_J;
            end
            6'd19, 6'd21: begin
                w_id  = XLEN'(w_opcode) + XLEN'(5);
                w_fmt = FMT_R;
            end
            default: begin
                w_id  = '0;
                w_fmt = FMT_R;
            end
        endcase
    end

    // Operand field extraction; an illegal opcode zeroes the whole payload
    always_comb begin
        w_rs = '0;
        w_rt = '0;
        w_rd = '0;
        if (!w_illegal) begin
            case (w_fmt)
                FMT_I: begin
                    w_rs = XLEN'(ir[25:21]);
                    w_rt = w_imm;
                    w_rd = XLEN'(ir[20:16]);
                end
                FMT_J: begin
                    w_rs = XLEN'(ir[25:0]);
                end
                default: begin
                    w_rs = XLEN'(ir[25:21]);
                    w_rt = XLEN'(ir[20:16]);
                    w_rd = XLEN'(ir[15:11]);
                end
            endcase
        end
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_id        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_illegal   <= 1'b0;
            r_count     <= '0;
        end else begin
            // Flush wins; an accept overrides a simultaneous consume (no bubble)
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_id      <= w_illegal ? '0 : w_id;
                r_rs      <= w_rs;
                r_rt      <= w_rt;
                r_rd      <= w_rd;
                r_illegal <= w_illegal;
                r_count   <= r_count + CNT_W'(1);
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign id          = r_id;
    assign rs          = r_rs;
    assign rt          = r_rt;
    assign rd          = r_rd;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default, sign-extending and 4-bit-counter
// instances share one stimulus stream and are checked against hand values.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] ir;

    logic        in_ready, out_valid, illegal;
    logic [31:0] id, rs, rt, rd;
    logic [15:0] instr_count;

    logic        sx_in_ready, sx_out_valid, sx_illegal;
    logic [31:0] sx_id, sx_rs, sx_rt, sx_rd;
    logic [15:0] sx_count;

    logic        c4_in_ready, c4_out_valid, c4_illegal;
    logic [31:0] c4_id, c4_rs, c4_rt, c4_rd;
    logic [3:0]  c4_count;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .out_valid(out_valid), .out_ready(out_ready), .id(id), .rs(rs),
        .rt(rt), .rd(rd), .illegal(illegal), .instr_count(instr_count)
    );

    decode_stage #(.SIGN_EXT(1)) dut_sx (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(sx_in_ready),
        .ir(ir), .out_valid(sx_out_valid), .out_ready(out_ready), .id(sx_id), .rs(sx_rs),
        .rt(sx_rt), .rd(sx_rd), .illegal(sx_illegal), .instr_count(sx_count)
    );

    decode_stage #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c4_in_ready),
        .ir(ir), .out_valid(c4_out_valid), .out_ready(out_ready), .id(c4_id), .rs(c4_rs),
        .rt(c4_rt), .rd(c4_rd), .illegal(c4_illegal), .instr_count(c4_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_payload(input string tag, input logic [31:0] e_id,
                                 input logic [31:0] e_rs, input logic [31:0] e_rt,
                                 input logic [31:0] e_rd, input logic e_ill);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".id"},    64'(id), 64'(e_id));
        check({tag, ".rs"},    64'(rs), 64'(e_rs));
        check({tag, ".rt"},    64'(rt), 64'(e_rt));
        check({tag, ".rd"},    64'(rd), 64'(e_rd));
        check({tag, ".ill"},   64'(illegal), 64'(e_ill));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ir = '0;
        #1;
        check("rst.valid", 64'(out_valid), 64'(0));
        check("rst.id", 64'(id), 64'(0));
        check("rst.count", 64'(instr_count), 64'(0));
        check("rst.in_ready", 64'(in_ready), 64'(1));

        // Valid input held during reset must not be accepted
        in_valid = 1'b1; ir = 32'h012A4020; out_ready = 1'b1;
        step();
        check("rst_hold.valid", 64'(out_valid), 64'(0));
        check("rst_hold.count", 64'(instr_count), 64'(0));
        rst = 1'b0;

        step();
        check_payload("r_op0", 32'd33, 32'd9, 32'd10, 32'd8, 1'b0);
        check("r_op0.count", 64'(instr_count), 64'(1));

        ir = 32'h2128FFFC;
        step();
        check_payload("i_op8", 32'd13, 32'd9, 32'h0000FFFC, 32'd8, 1'b0);
        check("i_op8.sx_rt", 64'(sx_rt), 64'h0000_0000_FFFF_FFFC);
        check("i_op8.count", 64'(instr_count), 64'(2));

        ir = 32'h08000010;
        step();
        check_payload("i_op2", 32'd6, 32'd0, 32'h10, 32'd0, 1'b0);

        ir = 32'h40000010;
        step();
        check_payload("j_op16", 32'd21, 32'h10, 32'd0, 32'd0, 1'b0);

        ir = 32'hFC000000;
        step();
        check_payload("ill_op63", 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        check("ill_op63.count", 64'(instr_count), 64'(5));

        ir = 32'h0C221800;
        step();
        check_payload("r_op3", 32'd7, 32'd1, 32'd2, 32'd3, 1'b0);

        ir = 32'h1C000005;
        step();
        check_payload("i_op7", 32'd16, 32'd0, 32'd5, 32'd0, 1'b0);
        check("i_op7.count", 64'(instr_count), 64'(7));

        // Backpressure: payload must hold while consumer stalls
        out_ready = 1'b0; ir = 32'h012A4020;
        #1;
        check("bp.in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            check_payload($sformatf("bp%0d", i), 32'd16, 32'd0, 32'd5, 32'd0, 1'b0);
            check($sformatf("bp%0d.count", i), 64'(instr_count), 64'(7));
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel.in_ready", 64'(in_ready), 64'(1));
        step();
        check_payload("bp_rep", 32'd33, 32'd9, 32'd10, 32'd8, 1'b0);
        check("bp_rep.count", 64'(instr_count), 64'(8));

        // Flush beats a simultaneous accept and consume
        flush = 1'b1; ir = 32'h0C221800;
        step();
        check("flush.valid", 64'(out_valid), 64'(0));
        check("flush.count", 64'(instr_count), 64'(8));
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("idle.valid", 64'(out_valid), 64'(0));

        // Nine more accepts: 17 total, 4-bit counter wraps to 1
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ir = 32'h08000010;
            step();
        end
        check("wrap.count16", 64'(instr_count), 64'(17));
        check("wrap.count4", 64'(c4_count), 64'(1));
        in_valid = 1'b0;
        step();
        check("drain.valid", 64'(out_valid), 64'(0));
        check("drain.count", 64'(instr_count), 64'(17));

        // Mid-cycle async reset while a result is held
        in_valid = 1'b1; out_ready = 1'b0; ir = 32'h0C221800;
        step();
        check_payload("pre_rst", 32'd7, 32'd1, 32'd2, 32'd3, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst.valid", 64'(out_valid), 64'(0));
        check("arst.id", 64'(id), 64'(0));
        check("arst.rs", 64'(rs), 64'(0));
        check("arst.rt", 64'(rt), 64'(0));
        check("arst.rd", 64'(rd), 64'(0));
        check("arst.count", 64'(instr_count), 64'(0));
        check("arst.count4", 64'(c4_count), 64'(0));
        check("arst.in_ready", 64'(in_ready), 64'(1));
        #1 rst = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; ir = 32'h012A4020;
        step();
        check_payload("post_rst", 32'd33, 32'd9, 32'd10, 32'd8, 1'b0);
        check("post_rst.count", 64'(instr_count), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
